aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Iterative AES encryption round sequencer. Accepts one 128-bit plaintext block through a valid/ready handshake and performs the initial AddRoundKey. It then drives the team's combinational round datapath (SubBytes → ShiftRows → MixColumns → AddRoundKey) once per cycle for NR rounds, requesting round keys by index from the key-expansion store. The ciphertext is presented through a valid/ready output handshake. It sits between the host-side block interface and the round datapath/key store.

## Interface

Parameters:
- NR, 10: number of rounds. Legal values are 10, 12 and 14 (AES-128/192/256). Any other value is a configuration error.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_block is valid
- in_ready  out  1  controller can accept a block
- in_block  in  128  plaintext, byte 0 in [127:120]
- rk_idx  out  4  round-key index requested from the key store
- rk  in  128  round key for rk_idx, returned combinationally in the same cycle
- dp_state  out  128  current state fed to the round datapath
- dp_final  out  1  final round: the datapath bypasses MixColumns
- dp_result  in  128  combinational round output for dp_state/rk
- out_valid  out  1  out_block holds ciphertext
- out_ready  in  1  consumer accepts out_block
- out_block  out  128  ciphertext
- busy  out  1  high in ROUND or DONE
- round  out  4  current round counter

## Operation

- Three-state FSM: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1, rk_idx=0.
  - On in_valid: state_reg ← in_block ^ rk, round ← 1, go to ROUND.
- ROUND:
  - rk_idx=round, dp_state=state_reg, dp_final=(round==NR).
  - Each cycle: state_reg ← dp_result.
  - If round==NR, go to DONE. Otherwise round ← round+1.
- DONE:
  - out_valid=1, out_block=state_reg, rk_idx=0.
  - On out_ready: go to IDLE, round ← 0.
  - state_reg holds until the next accept.
- in_ready is 0 in ROUND and DONE. in_valid in those states is ignored; the source must hold it.
- out_block is stable for as long as out_valid=1 and out_ready=0.
- dp_final=0 outside ROUND. dp_state=state_reg in all states.
- round is a 4-bit counter. It never exceeds NR, so there is no wrap.
- XOR is full 128-bit, with no byte reordering inside this block.

## Timing

- Reset values: FSM=IDLE, state_reg=0, round=0, in_ready=1, out_valid=0, busy=0, dp_final=0, rk_idx=0, out_block=0.
- Reset has priority over every other event. Asserting rst in ROUND or DONE discards the block in flight. The next cycle is IDLE with in_ready=1, and no out_valid pulse is produced.
- Accept edge: the cycle with in_valid&in_ready.
- out_valid rises NR+1 cycles after the accept cycle (accept cycle + NR round cycles). For NR=10: accept in cycle 0, out_valid first high in cycle 11.
- ROUND occupies exactly NR cycles. dp_final is high only in the last one.
- Output transfer: the cycle with out_valid&out_ready. IDLE, with in_ready=1, follows in the next cycle.
- Minimum block-to-block spacing is NR+2 cycles, with out_ready tied high.
- Backpressure: out_valid stays high, and ROUND is not re-entered, for as long as out_ready=0.
- Simultaneous events:
  - out_ready in the same cycle as in_valid while in DONE: only the output transfer occurs. The input is accepted in the following cycle at the earliest.
  - rst together with any handshake: reset wins and no transfer is counted.

## Test plan

- Bench setup: a behavioural round datapath and key-expansion model.
- FIPS-197 App. B, NR=10: key 2b7e151628aed2a6abf7158809cf4f3c, in_block 3243f6a8885a308d313198a2e0370734 → out_block 3925841d02dc09fbdc118597196a0b32; out_valid in cycle 11 after accept.
- FIPS-197 App. C.1, NR=10: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a. Also check rk_idx sequence 0,1..10 and dp_final high in exactly one cycle.
- Backpressure and in_valid-while-busy:
  - Hold out_ready=0 for 20 cycles after out_valid → out_block stable, in_ready=0 throughout.
  - Drive in_valid while busy → the second block is accepted only in the cycle after the output transfer.
  - Both ciphertexts must be correct.
- Mid-operation reset: assert rst in round 5 → next cycle IDLE, round=0, out_valid=0, in_ready=1. A fresh App. B block is then correct.
- Back-to-back streaming with out_ready=1 and in_valid=1 over 4 blocks → each out_valid is spaced exactly 12 cycles apart, and the ciphertexts match the model.
- NR=14 with the FIPS-197 App. C.3 key 000102…1e1f and plaintext 00112233445566778899aabbccddeeff → out_block 8ea2b7ca516745bfeafc49904b496089; out_valid in cycle 15.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
//
// Iterative AES encryption round sequencer. A plaintext block is accepted on
// a valid/ready handshake and whitened with round key 0. The controller then
// steps an external combinational round datapath once per cycle for NR
// rounds. It fetches round keys by index from the key-expansion store and
// presents the ciphertext on a valid/ready output handshake.
//
// Parameters
//   NR         number of rounds: 10, 12 or 14 (AES-128/192/256)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset, highest priority
//   in_valid   plaintext block valid
//   in_ready   controller can accept a block (IDLE only)
//   in_block   plaintext, byte 0 in [127:120]
//   rk_idx     round-key index requested from the key store
//   rk         round key for rk_idx, returned combinationally
//   dp_state   state fed to the round datapath
//   dp_final   final round, so the datapath skips MixColumns
//   dp_result  combinational round output for dp_state/rk
//   out_valid  out_block holds ciphertext
//   out_ready  consumer accepts out_block
//   out_block  ciphertext
//   busy       high while a block is in ROUND or DONE
//   round      current round counter
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic [127:0] dp_state,
  output logic         dp_final,
  input  logic [127:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy,
  output logic [3:0]   round
);

  // Only the three AES key sizes are meaningful round counts.
  if (!((NR == 10) || (NR == 12) || (NR == 14))) begin : g_bad_nr
    $error("aes_round_ctrl: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] C_NR = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t       r_fsm;
  logic [127:0] r_state;
  logic [3:0]   r_round;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;
  logic         r_dp_final;
  logic [3:0]   r_rk_idx;

  logic         w_last;
  logic [3:0]   w_round_nxt;

  assign w_last      = (r_round == C_NR);
  assign w_round_nxt = r_round + 4'd1;

  // The rk_idx and dp_final outputs are registered. They are loaded with the
  // values for the round that the state will be in after this edge, so the
  // key store and the datapath see them in the same cycle as that round.
  // Sequencer FSM: block state, round counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= S_IDLE;
      r_state     <= 128'd0;
      r_round     <= 4'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_dp_final  <= 1'b0;
      r_rk_idx    <= 4'd0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            // Initial AddRoundKey with key 0 (rk_idx is 0 in IDLE).
            r_state    <= in_block ^ rk;
            r_round    <= 4'd1;
            r_fsm      <= S_ROUND;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_rk_idx   <= 4'd1;
            r_dp_final <= 1'b0;
          end else begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_rk_idx   <= 4'd0;
            r_dp_final <= 1'b0;
          end
        end
        S_ROUND: begin
          r_state <= dp_result;
          if (w_last) begin
            r_fsm       <= S_DONE;
            r_out_valid <= 1'b1;
            r_rk_idx    <= 4'd0;
            r_dp_final  <= 1'b0;
          end else begin
            r_round    <= w_round_nxt;
            r_rk_idx   <= w_round_nxt;
            r_dp_final <= (w_round_nxt == C_NR);
          end
        end
        S_DONE: begin
          // The ciphertext stays in r_state until the next block is accepted.
          if (out_ready) begin
            r_fsm       <= S_IDLE;
            r_round     <= 4'd0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: return to a clean IDLE.
          r_fsm       <= S_IDLE;
          r_round     <= 4'd0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_dp_final  <= 1'b0;
          r_rk_idx    <= 4'd0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign dp_final  = r_dp_final;
  assign rk_idx    = r_rk_idx;
  assign round     = r_round;
  assign dp_state  = r_state;
  assign out_block = r_state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
//
// This bench drives two sequencers, one with NR=10 and one with NR=14. Each
// is surrounded by a behavioural AES round datapath and key store. A
// cycle-level monitor follows the spec's timeline for the selected instance:
// idle, rounds 1..NR, then done. Ciphertexts come from a reference AES
// encryption function.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_block;
  logic         sel;   // 0: NR=10 instance, 1: NR=14 instance

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] b;
    int e;
    r = 8'h01;
    b = x;
    e = 254;
    while (e != 0) begin
      if (e % 2 == 1) r = gmul(r, b);
      b = gmul(b, b);
      e = e / 2;
    end
    if (x == 8'h00) r = 8'h00;
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s,
                                              input logic [127:0] k,
                                              input logic fin);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        t[4*c+w] = b[4*((c+w)%4)+w];
    for (int c = 0; c < 4; c++) begin
      if (fin) begin
        for (int w = 0; w < 4; w++) b[4*c+w] = t[4*c+w];
      end else begin
        b[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
        b[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
        b[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
        b[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r ^ k;
  endfunction

  // The key is left-aligned in 256 bits. nk is 4, 6 or 8 words. Round key r
  // sits at [1919-128*r -: 128].
  function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1919:0] o;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    o  = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      o[1919-128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return o;
  endfunction

  function automatic logic [127:0] rk_of(input logic [1919:0] ks, input logic [3:0] idx);
    return ks[1919-128*int'(idx) -: 128];
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt,
                                                input logic [1919:0] ks,
                                                input int nr);
    logic [127:0] s;
    s = pt ^ rk_of(ks, 4'd0);
    for (int r = 1; r <= nr; r++) s = aes_round(s, rk_of(ks, 4'(r)), r == nr);
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- DUTs with datapath and key store ----------------
  logic [1919:0] ks_a, ks_b;

  logic a_in_valid, a_in_ready, a_dp_final, a_out_valid, a_busy;
  logic [3:0] a_rk_idx, a_round;
  logic [127:0] a_rk, a_dp_state, a_dp_result, a_out_block;
  logic b_in_valid, b_in_ready, b_dp_final, b_out_valid, b_busy;
  logic [3:0] b_rk_idx, b_round;
  logic [127:0] b_rk, b_dp_state, b_dp_result, b_out_block;

  assign a_in_valid  = in_valid & ~sel;
  assign b_in_valid  = in_valid & sel;
  assign a_rk        = rk_of(ks_a, a_rk_idx);
  assign b_rk        = rk_of(ks_b, b_rk_idx);
  assign a_dp_result = aes_round(a_dp_state, a_rk, a_dp_final);
  assign b_dp_result = aes_round(b_dp_state, b_rk, b_dp_final);

  aes_round_ctrl #(.NR(10)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_block(in_block), .rk_idx(a_rk_idx), .rk(a_rk), .dp_state(a_dp_state),
    .dp_final(a_dp_final), .dp_result(a_dp_result), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_block(a_out_block), .busy(a_busy), .round(a_round)
  );

  aes_round_ctrl #(.NR(14)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_block(in_block), .rk_idx(b_rk_idx), .rk(b_rk), .dp_state(b_dp_state),
    .dp_final(b_dp_final), .dp_result(b_dp_result), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_block(b_out_block), .busy(b_busy), .round(b_round)
  );

  // Views of the selected instance.
  logic m_in_ready, m_dp_final, m_out_valid, m_busy;
  logic [3:0] m_rk_idx, m_round;
  logic [127:0] m_dp_state, m_out_block;
  logic [1919:0] m_ks;
  int cur_nr;
  assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign m_dp_final  = sel ? b_dp_final  : a_dp_final;
  assign m_out_valid = sel ? b_out_valid : a_out_valid;
  assign m_busy      = sel ? b_busy      : a_busy;
  assign m_rk_idx    = sel ? b_rk_idx    : a_rk_idx;
  assign m_round     = sel ? b_round     : a_round;
  assign m_dp_state  = sel ? b_dp_state  : a_dp_state;
  assign m_out_block = sel ? b_out_block : a_out_block;
  assign m_ks        = sel ? ks_b        : ks_a;
  assign cur_nr      = sel ? 14 : 10;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- Timeline monitor ----------------
  // m_k: 0 idle, 1..NR round number, NR+1 done. Sampled mid-cycle.
  int m_k = 0;
  logic [127:0] m_exp = '0;
  logic [127:0] m_hold = '0;
  bit mon_en = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (m_k == 0) begin
          check_val("idle_in_ready",  128'(m_in_ready), 128'd1);
          check_val("idle_out_valid", 128'(m_out_valid), 128'd0);
          check_val("idle_busy",      128'(m_busy), 128'd0);
          check_val("idle_dp_final",  128'(m_dp_final), 128'd0);
          check_val("idle_rk_idx",    128'(m_rk_idx), 128'd0);
          check_val("idle_round",     128'(m_round), 128'd0);
          check_val("idle_out_block", m_out_block, m_hold);
          check_val("idle_dp_state",  m_dp_state, m_hold);
        end else if (m_k <= cur_nr) begin
          check_val("rnd_in_ready",  128'(m_in_ready), 128'd0);
          check_val("rnd_out_valid", 128'(m_out_valid), 128'd0);
          check_val("rnd_busy",      128'(m_busy), 128'd1);
          check_val("rnd_rk_idx",    128'(m_rk_idx), 128'(m_k));
          check_val("rnd_round",     128'(m_round), 128'(m_k));
          check_val("rnd_dp_final",  128'(m_dp_final), 128'(m_k == cur_nr));
        end else begin
          check_val("done_out_valid", 128'(m_out_valid), 128'd1);
          check_val("done_in_ready",  128'(m_in_ready), 128'd0);
          check_val("done_busy",      128'(m_busy), 128'd1);
          check_val("done_rk_idx",    128'(m_rk_idx), 128'd0);
          check_val("done_dp_final",  128'(m_dp_final), 128'd0);
          check_val("done_out_block", m_out_block, m_exp);
          check_val("done_dp_state",  m_dp_state, m_exp);
        end
      end
      // Advance the model to the state that follows the coming edge.
      if (rst) begin
        m_k    = 0;
        m_hold = '0;
        mon_en = 1'b1;
      end else if (mon_en) begin
        if (m_k == 0) begin
          if (in_valid) begin
            m_exp = aes_encrypt(in_block, m_ks, cur_nr);
            m_k   = 1;
          end
        end else if (m_k <= cur_nr) begin
          m_k = m_k + 1;
        end else if (out_ready) begin
          m_hold = m_exp;
          m_k    = 0;
        end
      end
    end
  end

  // ---------------- Stimulus ----------------
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KC3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CC3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(output int cnt);
    cnt = 1;
    while (!m_out_valid && cnt < 40) begin
      step();
      cnt++;
    end
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (!m_in_ready && cnt < 60) begin
      step();
      cnt++;
    end
    check_val("idle_reached", 128'(m_in_ready), 128'd1);
  endtask

  task automatic run_kat(input string tag, input logic [255:0] key, input int nk,
                         input logic [127:0] pt, input logic [127:0] ct);
    int cnt;
    int nfin;
    if (sel) ks_b = expand_key(key, nk);
    else     ks_a = expand_key(key, nk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_block  = pt;
    check_val("kat_in_ready", 128'(m_in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    in_block = rand128();
    cnt  = 1;
    nfin = 0;
    while (!m_out_valid && cnt < 40) begin
      if (m_dp_final) nfin++;
      step();
      cnt++;
    end
    check_val("kat_latency", 128'(cnt), 128'(cur_nr + 1));
    check_val("kat_dp_final_count", 128'(nfin), 128'd1);
    check_val(tag, m_out_block, ct);
    step();
    check_val("kat_post_xfer_in_ready", 128'(m_in_ready), 128'd1);
  endtask

  initial begin
    logic [127:0] pt1, pt2, e1, e2;
    logic [127:0] exp_q [$];
    int cnt, cyc, nacc, nout, last_ov;
    bit acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_block = '0; sel = 1'b0;
    ks_a = expand_key({KB, 128'd0}, 4);
    ks_b = expand_key(KC3, 8);
    repeat (3) step();
    rst = 1'b0;
    check_val("reset_out_block", m_out_block, 128'd0);
    check_val("reset_in_ready", 128'(m_in_ready), 128'd1);

    // Known answers, NR=10.
    run_kat("kat_app_b", {KB, 128'd0}, 4, PB, CB);
    run_kat("kat_app_c1", {KC1, 128'd0}, 4, PC, CC1);

    // Backpressure with the next block already waiting.
    ks_a = expand_key({rand128(), 128'd0}, 4);
    pt1 = rand128(); pt2 = rand128();
    e1 = aes_encrypt(pt1, ks_a, 10);
    e2 = aes_encrypt(pt2, ks_a, 10);
    out_ready = 1'b0; in_valid = 1'b1; in_block = pt1;
    step();
    in_block = pt2;
    wait_out_valid(cnt);
    check_val("bp_latency", 128'(cnt), 128'd11);
    for (int i = 0; i < 20; i++) begin
      check_val("bp_out_block", m_out_block, e1);
      check_val("bp_in_ready", 128'(m_in_ready), 128'd0);
      check_val("bp_out_valid", 128'(m_out_valid), 128'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    check_val("bp_no_accept_on_xfer", 128'(m_busy), 128'd0);
    step();
    check_val("bp_second_accepted", 128'(m_busy), 128'd1);
    in_valid = 1'b0;
    wait_out_valid(cnt);
    check_val("bp_second_latency", 128'(cnt), 128'd11);
    check_val("bp_second_block", m_out_block, e2);
    step();

    // Reset in round 5, then a fresh App. B block.
    ks_a = expand_key({KB, 128'd0}, 4);
    in_valid = 1'b1; in_block = PB;
    step();
    in_valid = 1'b0;
    cnt = 0;
    while (m_round != 4'd5 && cnt < 20) begin
      step();
      cnt++;
    end
    check_val("rst_round5_reached", 128'(m_round), 128'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("rst_in_ready", 128'(m_in_ready), 128'd1);
    check_val("rst_out_valid", 128'(m_out_valid), 128'd0);
    check_val("rst_round", 128'(m_round), 128'd0);
    run_kat("kat_app_b_after_rst", {KB, 128'd0}, 4, PB, CB);

    // Streaming with both handshakes held high.
    ks_a = expand_key({rand128(), 128'd0}, 4);
    out_ready = 1'b1; in_valid = 1'b1; in_block = rand128();
    nacc = 0; nout = 0; last_ov = -1; cyc = 0;
    while (nout < 4 && cyc < 200) begin
      acc = in_valid && m_in_ready;
      if (acc) exp_q.push_back(aes_encrypt(in_block, ks_a, 10));
      if (m_out_valid) begin
        check_val("stream_queue", 128'(exp_q.size() > 0), 128'd1);
        if (exp_q.size() > 0) check_val("stream_block", m_out_block, exp_q.pop_front());
        if (last_ov >= 0) check_val("stream_spacing", 128'(cyc - last_ov), 128'd12);
        last_ov = cyc;
        nout++;
      end
      step();
      cyc++;
      if (acc) begin
        nacc++;
        if (nacc >= 4) in_valid = 1'b0;
        else in_block = rand128();
      end
    end
    check_val("stream_outputs", 128'(nout), 128'd4);
    step();

    // Random handshakes with occasional resets.
    ks_a = expand_key({rand128(), 128'd0}, 4);
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      if (!in_valid) begin
        in_valid = $urandom_range(0, 1) == 1;
        in_block = rand128();
      end
      acc = in_valid && m_in_ready && !rst;
      step();
      if (acc) begin
        in_valid = $urandom_range(0, 1) == 1;
        in_block = rand128();
      end
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    wait_idle();

    // Switch to the NR=14 instance across a reset.
    rst = 1'b1;
    step();
    sel = 1'b1;
    step();
    rst = 1'b0;
    run_kat("kat_app_c3", KC3, 8, PC, CC3);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
